score_bcd_serial: RTL and testbench
===================================

# score_bcd_serial

Parametrised, multi-cycle binary-to-BCD converter for score and counter displays, using the shift-and-add-3 (double-dabble) algorithm. It processes one input bit per clock, so no wide dividers or modulo operators are built. A start/busy/done handshake connects it between the score counter and the seven-segment digit decoders. Results wider than the digit count are flagged and reduced modulo 10^DIGITS.

## Interface
- BIN_W, default 10: width of the binary input; must be ≥ 1.
- DIGITS, default 4: number of BCD output digits; must be ≥ 1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion of bin_in; sampled only when the block is not busy.
- bin_in  in  BIN_W  unsigned binary value; sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd_out and overflow are updated in the same cycle.
- bcd_out  out  4*DIGITS  result digits; digit 0 (units) is in bits [3:0]; held until the next done.
- overflow  out  1  bin_in ≥ 10^DIGITS for the last completed conversion; held with bcd_out.

## Operation
- The FSM has two states, IDLE and SHIFT.
- **IDLE, start=1:**
  - Load the bit shift register with bin_in.
  - Clear the BCD working register and the sticky overflow bit.
  - Set the bit counter to BIN_W, set busy=1 and go to SHIFT.
- **IDLE, start=0:** remain in IDLE.
- **Each SHIFT edge:**
  - Add 3 to every working digit that is ≥ 5.
  - Shift the concatenation {work, bin} left by one.
  - OR the bit leaving the top digit's MSB into the sticky overflow bit.
  - Decrement the counter.
- **Final SHIFT edge (counter = 1):**
  - Write the post-shift working digits to bcd_out and the sticky bit (including this edge's carry-out) to overflow.
  - Pulse done=1, drive busy=0 and return to IDLE.
- **Overflow:** bcd_out = bin_in mod 10^DIGITS and overflow=1. This is the only wrap-around behaviour.
- **Non-overflow:** bcd_out equals the exact decimal value of bin_in.
- **start while busy:** ignored; no queueing and no error.
- **start in the done cycle:** the block is in IDLE, so start is accepted (back-to-back operation).
- **Reset:**
  - bcd_out=0, overflow=0, busy=0, done=0; state IDLE; working and shift registers cleared.
  - Asserting reset mid-conversion aborts it; done is never produced for an aborted conversion.
- **No-overflow configurations:** if 2^BIN_W ≤ 10^DIGITS, overflow is constant 0 in practice, but the logic stays.

## Timing
- Accept edge = edge k. busy is high in cycles k+1 … k+BIN_W.
- The final shift happens at edge k+BIN_W. done and the new bcd_out are visible after edge k+BIN_W, so latency is BIN_W cycles from the accept edge.
- Maximum throughput: one conversion per BIN_W+1 cycles.
- done and busy are never high in the same cycle.
- Critical path: a single digit add-3 stage plus the shift; it is independent of BIN_W and DIGITS.

## Configuration
- Macro: SCORE_BCD_BLANK_EN.
- **Defined:** at the done-capture edge, leading zero digits in bcd_out are replaced with 4'hF (the decoder's blank code).
  - Digit 0 is never blanked, so value 0 gives ...FFF0.
  - Blanking is applied to the modulo result when overflow=1.
- **Undefined:** all digits are output as plain BCD 0–9 and no blanking logic is synthesised.

## Structure
- Package score_bcd_pkg holds:
  - the state enum (IDLE, SHIFT);
  - DIGIT_W = 4;
  - BLANK_CODE = 4'hF;
  - ADJ_THRESH = 5;
  - ADJ_ADD = 3.
- Sub-module bcd_digit_adj: combinational per-digit "if ≥ 5 then +3", instantiated DIGITS times from a generate loop.
- The counter width is $clog2(BIN_W+1).

## Test plan
- Defaults, bin_in=0, start pulse → done exactly 10 cycles after the accept edge; bcd_out=16'h0000; overflow=0.
- Defaults, bin_in=1023 → bcd_out=16'h1023; overflow=0. Also sweep all 1024 values against a decimal reference model.
- DIGITS=3, bin_in=1023 → bcd_out=12'h023; overflow=1. For bin_in=999 → 12'h999; overflow=0.
- start held high throughout → conversions accepted only at the start and in each done cycle, one result per 11 cycles. bin_in changing while busy does not affect the result.
- rst_n asserted at cycle 5 of a conversion → outputs are 0 immediately (async). No done follows. The next start converts correctly.
- With SCORE_BCD_BLANK_EN: bin_in=7 → 16'hFFF7; 0 → 16'hFFF0; 100 → 16'hF100.

Source files
------------

// File: rtl/score_bcd_pkg.sv
// Shared types and constants for the serial double-dabble binary-to-BCD converter.
package score_bcd_pkg;

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit correction: add 3 to a digit of 5 or more before the shift.
module bcd_digit_adj
  import score_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i + ADJ_ADD : digit_i;

endmodule

// File: rtl/score_bcd_serial.sv
// Multi-cycle binary-to-BCD converter, one input bit per clock, with start/busy/done handshake.
// Optional leading-zero blanking is enabled by defining SCORE_BCD_BLANK_EN.
module score_bcd_serial
  import score_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      overflow
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = DIGIT_W * DIGITS;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d, bin_shift;
  logic [BCD_W-1:0] work_q, work_d, work_adj, work_shift, bcd_fmt;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             carry;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i(work_q[i*DIGIT_W +: DIGIT_W]),
      .digit_o(work_adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  // A carry out of the top digit stands for 10^DIGITS, so the working register keeps the modulo.
  assign {carry, work_shift, bin_shift} = {work_adj, bin_q, 1'b0};

`ifdef SCORE_BCD_BLANK_EN
  logic lead;

  always_comb begin
    bcd_fmt = work_shift;
    lead    = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (work_shift[i*DIGIT_W +: DIGIT_W] == '0)) begin
        bcd_fmt[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign bcd_fmt = work_shift;
`endif

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d    = bin_in;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_W);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        work_d   = work_shift;
        bin_d    = bin_shift;
        sticky_d = sticky_q | carry;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = bcd_fmt;
          ovf_d   = sticky_q | carry;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_bcd_serial.sv
// Directed bench for score_bcd_serial: default 10-bit/4-digit instance plus a 3-digit instance.
module tb_score_bcd_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  bin_in = '0;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;
  logic        start3 = 1'b0;
  logic [9:0]  bin3 = '0;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  score_bcd_serial u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  score_bcd_serial #(.BIN_W(10), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bin_in(bin3),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
  );

  // Decimal reference built by division, independent of the shift-and-add datapath.
  function automatic logic [15:0] model(input int v, input int nd);
    int x;
    logic [15:0] r;
    x = v % (10 ** nd);
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef SCORE_BCD_BLANK_EN
    for (int i = nd - 1; i >= 1; i--) begin
      if (r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
      else break;
    end
`endif
    return r;
  endfunction

  // Drives one conversion and reports result and latency in cycles after the accept edge.
  task automatic do_conv(input bit sel, input int v, output logic [15:0] b, output logic o,
                         output int lat);
    @(negedge clk);
    if (sel) begin start3 = 1'b1; bin3 = 10'(v); end
    else begin start = 1'b1; bin_in = 10'(v); end
    @(posedge clk);
    #1;
    start  = 1'b0;
    start3 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (sel ? done3 : done) begin
        lat = c;
        break;
      end
    end
    b = sel ? {4'h0, bcd3} : bcd_out;
    o = sel ? ovf3 : overflow;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h want=0000", bcd_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    logic [15:0] b; logic o; int lat;
    do_conv(1'b0, 0, b, o, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL zero_latency got=%0d want=10", lat); end
`ifdef SCORE_BCD_BLANK_EN
    total++; if (b !== 16'hFFF0) begin bad++; $display("FAIL zero_bcd got=%h want=fff0", b); end
`else
    total++; if (b !== 16'h0000) begin bad++; $display("FAIL zero_bcd got=%h want=0000", b); end
`endif
    total++; if (o !== 1'b0) begin bad++; $display("FAIL zero_ovf got=%b want=0", o); end
  endtask

  task automatic test_max();
    logic [15:0] b; logic o; int lat;
    do_conv(1'b0, 1023, b, o, lat);
    total++; if (b !== 16'h1023) begin bad++; $display("FAIL max_bcd got=%h want=1023", b); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL max_ovf got=%b want=0", o); end
  endtask

  task automatic test_sweep();
    logic [15:0] b; logic o; int lat;
    for (int v = 0; v < 1024; v++) begin
      do_conv(1'b0, v, b, o, lat);
      total++;
      if (b !== model(v, 4) || o !== 1'b0 || lat !== 10) begin
        bad++;
        $display("FAIL sweep v=%0d got=%h/%b/%0d want=%h/0/10", v, b, o, lat, model(v, 4));
      end
    end
  endtask

  task automatic test_digits3();
    logic [15:0] b; logic o; int lat;
    do_conv(1'b1, 1023, b, o, lat);
`ifdef SCORE_BCD_BLANK_EN
    total++; if (b[11:0] !== 12'hF23) begin bad++; $display("FAIL d3_1023 got=%h want=f23", b[11:0]); end
`else
    total++; if (b[11:0] !== 12'h023) begin bad++; $display("FAIL d3_1023 got=%h want=023", b[11:0]); end
`endif
    total++; if (o !== 1'b1) begin bad++; $display("FAIL d3_1023_ovf got=%b want=1", o); end
    do_conv(1'b1, 999, b, o, lat);
    total++; if (b[11:0] !== 12'h999) begin bad++; $display("FAIL d3_999 got=%h want=999", b[11:0]); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL d3_999_ovf got=%b want=0", o); end
    do_conv(1'b1, 1000, b, o, lat);
`ifdef SCORE_BCD_BLANK_EN
    total++; if (b[11:0] !== 12'hFF0) begin bad++; $display("FAIL d3_1000 got=%h want=ff0", b[11:0]); end
`else
    total++; if (b[11:0] !== 12'h000) begin bad++; $display("FAIL d3_1000 got=%h want=000", b[11:0]); end
`endif
    total++; if (o !== 1'b1) begin bad++; $display("FAIL d3_1000_ovf got=%b want=1", o); end
  endtask

  task automatic test_back_to_back();
    int vals[3] = '{37, 512, 999};
    int idx = 0;
    int last = 0;
    int want_gap;
    bit both = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 10'(vals[0]);
    @(posedge clk);
    #1;
    bin_in = 10'($urandom);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      #1;
      if (busy && done) both = 1'b1;
      if (done) begin
        want_gap = (idx == 0) ? 10 : 11;
        total++;
        if (cyc - last !== want_gap) begin
          bad++; $display("FAIL b2b_gap idx=%0d got=%0d want=%0d", idx, cyc - last, want_gap);
        end
        total++;
        if (bcd_out !== model(vals[idx], 4)) begin
          bad++; $display("FAIL b2b_bcd idx=%0d got=%h want=%h", idx, bcd_out, model(vals[idx], 4));
        end
        last = cyc;
        idx++;
        if (idx == 3) break;
        bin_in = 10'(vals[idx]);
      end else begin
        bin_in = 10'($urandom);
      end
    end
    start = 1'b0;
    total++; if (idx !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", idx); end
    total++; if (both !== 1'b0) begin bad++; $display("FAIL b2b_busy_done_overlap got=1 want=0"); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] b; logic o; int lat;
    bit seen = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 10'd1023;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL abort_bcd got=%h want=0000", bcd_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL abort_ovf got=%b want=0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=1 want=0"); end
    do_conv(1'b0, 456, b, o, lat);
    total++; if (b !== 16'h0456) begin bad++; $display("FAIL abort_next got=%h want=0456", b); end
  endtask

  task automatic test_blank();
    logic [15:0] b; logic o; int lat;
    do_conv(1'b0, 7, b, o, lat);
`ifdef SCORE_BCD_BLANK_EN
    total++; if (b !== 16'hFFF7) begin bad++; $display("FAIL blank_7 got=%h want=fff7", b); end
`else
    total++; if (b !== 16'h0007) begin bad++; $display("FAIL blank_7 got=%h want=0007", b); end
`endif
    do_conv(1'b0, 100, b, o, lat);
`ifdef SCORE_BCD_BLANK_EN
    total++; if (b !== 16'hF100) begin bad++; $display("FAIL blank_100 got=%h want=f100", b); end
`else
    total++; if (b !== 16'h0100) begin bad++; $display("FAIL blank_100 got=%h want=0100", b); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_digits3();
    test_back_to_back();
    test_reset_abort();
    test_blank();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
